// File: rtl/div_unit.sv
// Iterative radix-2 integer divider for the EX stage: one quotient bit per cycle,
// with a stall request held until the registered quotient/remainder are ready for HI/LO.
module div_unit #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          div_req,
   input  logic          div_signed,
   input  logic [DW-1:0] div_src1,
   input  logic [DW-1:0] div_src2,
   input  logic          div_ack,
   input  logic          div_cancel,
   output logic          div_stop,
   output logic          div_done,
   output logic [DW-1:0] div_q,
   output logic [DW-1:0] div_r
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2*DW-1:0]   shift_q, shift_d;
   logic [DW-1:0]     divisor_q, divisor_d;
   logic [DW-1:0]     dividend_q, dividend_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              dz_q, dz_d;
   logic              done_q, done_d;
   logic [DW-1:0]     quot_q, quot_d;
   logic [DW-1:0]     rem_q, rem_d;

   logic [DW-1:0]     absSrc1, absSrc2;
   logic [DW:0]       trial;
   logic [2*DW-1:0]   stepShift;
   logic [DW-1:0]     finalQ, finalR;
   logic [DW-1:0]     resQ, resR;

   // The shifted-out partial remainder can be DW+1 bits wide, so the trial
   // subtraction is DW+1 bits and its MSB is exactly the borrow.
   always_comb begin
      absSrc1   = (div_signed && div_src1[DW-1]) ? (~div_src1 + 1'b1) : div_src1;
      absSrc2   = (div_signed && div_src2[DW-1]) ? (~div_src2 + 1'b1) : div_src2;
      trial     = shift_q[2*DW-1:DW-1] - {1'b0, divisor_q};
      stepShift = trial[DW] ? {shift_q[2*DW-2:0], 1'b0}
                            : {trial[DW-1:0], shift_q[DW-2:0], 1'b1};
      finalQ    = stepShift[DW-1:0];
      finalR    = stepShift[2*DW-1:DW];
      resQ      = dz_q ? {DW{1'b1}} : (qneg_q ? (~finalQ + 1'b1) : finalQ);
      resR      = dz_q ? dividend_q : (rneg_q ? (~finalR + 1'b1) : finalR);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      divisor_d  = divisor_q;
      dividend_d = dividend_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      dz_d       = dz_q;
      done_d     = done_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      case (state_q)
         IDLE: begin
            if (div_req && !div_cancel) begin
               state_d    = BUSY;
               cnt_d      = 6'd0;
               shift_d    = {{DW{1'b0}}, absSrc1};
               divisor_d  = absSrc2;
               dividend_d = div_src1;
               qneg_d     = div_signed & (div_src1[DW-1] ^ div_src2[DW-1]);
               rneg_d     = div_signed & div_src1[DW-1];
               dz_d       = (div_src2 == '0);
            end
         end
         BUSY: begin
            // A kill or the instruction vanishing from EX abandons the divide.
            if (div_cancel || !div_req) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end else begin
               shift_d = stepShift;
               cnt_d   = cnt_q + 6'd1;
               if (cnt_q == 6'(DW - 1)) begin
                  state_d = DONE;
                  quot_d  = resQ;
                  rem_d   = resR;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            if (div_cancel || div_ack) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         shift_q    <= '0;
         divisor_q  <= '0;
         dividend_q <= '0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         dz_q       <= 1'b0;
         done_q     <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         divisor_q  <= divisor_d;
         dividend_q <= dividend_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         dz_q       <= dz_d;
         done_q     <= done_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
      end
   end

   assign div_stop = resetn && div_req && !div_cancel && (state_q != DONE);
   assign div_done = done_q;
   assign div_q    = quot_q;
   assign div_r    = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table of signed/unsigned divides plus
// hand sequences for back-pressure, back-to-back, cancel, req drop and reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        div_req, div_signed, div_ack, div_cancel;
   logic [31:0] div_src1, div_src2;
   logic        div_stop, div_done;
   logic [31:0] div_q, div_r;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[11];

   div_unit #(.DW(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .div_req   (div_req),
      .div_signed(div_signed),
      .div_src1  (div_src1),
      .div_src2  (div_src2),
      .div_ack   (div_ack),
      .div_cancel(div_cancel),
      .div_stop  (div_stop),
      .div_done  (div_done),
      .div_q     (div_q),
      .div_r     (div_r)
   );

   always #5 clk = ~clk;

   // Hard bound so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      div_req    = 1'b1;
      div_signed = sgn;
      div_src1   = a;
      div_src2   = b;
   endtask

   // Called in the acceptance cycle T; leaves the bench in cycle T+33 (DONE, not acked).
   task automatic runToDone(input string name, input logic [31:0] expQ, input logic [31:0] expR);
      int stopCycles = 0;
      #1;
      if (div_stop && !div_done) stopCycles++;
      for (int i = 1; i <= 32; i++) begin
         nextCycle();
         div_src1   = $urandom;
         div_src2   = $urandom;
         div_signed = 1'($urandom_range(0, 1));
         #1;
         if (div_stop && !div_done) stopCycles++;
      end
      nextCycle();
      #1;
      checkOutput({name, " stopCycles"}, 32'(stopCycles), 32'd33);
      checkOutput({name, " done"}, {31'd0, div_done}, 32'd1);
      checkOutput({name, " stopAtDone"}, {31'd0, div_stop}, 32'd0);
      checkOutput({name, " q"}, div_q, expQ);
      checkOutput({name, " r"}, div_r, expR);
   endtask

   initial begin
      int bad;
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      vecs[4]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
      vecs[5]  = '{1'b1, 32'h8000_0001,  32'd0,          32'hFFFF_FFFF,  32'h8000_0001};
      vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[7]  = '{1'b0, 32'd5,          32'd16,         32'd0,          32'd5};
      vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
      vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
      vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

      resetn     = 1'b0;
      div_req    = 1'b1;
      div_signed = 1'b0;
      div_src1   = 32'd0;
      div_src2   = 32'd0;
      div_ack    = 1'b0;
      div_cancel = 1'b0;
      #12;
      checkOutput("reset stop", {31'd0, div_stop}, 32'd0);
      checkOutput("reset done", {31'd0, div_done}, 32'd0);
      checkOutput("reset q", div_q, 32'd0);
      checkOutput("reset r", div_r, 32'd0);
      div_req = 1'b0;
      resetn  = 1'b1;
      nextCycle();

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
         runToDone($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
         div_ack = 1'b1;
         nextCycle();
         div_ack = 1'b0;
         div_req = 1'b0;
         #1;
         checkOutput($sformatf("vec%0d doneCleared", i), {31'd0, div_done}, 32'd0);
      end

      // Back-pressure in DONE, then a second divide waiting behind the ack.
      applyStimulus(1'b0, 32'd1000, 32'd33);
      runToDone("bp first", 32'd30, 32'd10);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         #1;
         if (!div_done || div_stop || div_q !== 32'd30 || div_r !== 32'd10) bad++;
      end
      checkOutput("bp held", 32'(bad), 32'd0);
      div_ack = 1'b1;
      nextCycle();
      div_ack = 1'b0;
      applyStimulus(1'b0, 32'd9, 32'd3);
      #1;
      checkOutput("b2b idle done", {31'd0, div_done}, 32'd0);
      runToDone("b2b second", 32'd3, 32'd0);
      div_ack = 1'b1;
      nextCycle();
      div_ack = 1'b0;
      div_req = 1'b0;

      // Cancel at T+10, restart at T+11.
      nextCycle();
      applyStimulus(1'b0, 32'd85, 32'd5);
      repeat (10) nextCycle();
      div_cancel = 1'b1;
      #1;
      checkOutput("cancel stop", {31'd0, div_stop}, 32'd0);
      nextCycle();
      div_cancel = 1'b0;
      applyStimulus(1'b0, 32'd10, 32'd4);
      #1;
      checkOutput("cancel done", {31'd0, div_done}, 32'd0);
      checkOutput("cancel q kept", div_q, 32'd3);
      checkOutput("cancel r kept", div_r, 32'd0);
      runToDone("cancel restart", 32'd2, 32'd2);
      div_ack = 1'b1;
      nextCycle();
      div_ack = 1'b0;
      div_req = 1'b0;

      // Request dropping mid-BUSY aborts like a cancel.
      nextCycle();
      applyStimulus(1'b0, 32'd50, 32'd7);
      repeat (5) nextCycle();
      div_req = 1'b0;
      #1;
      checkOutput("drop stop", {31'd0, div_stop}, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 32'd64, 32'd8);
      runToDone("drop restart", 32'd8, 32'd0);
      div_ack = 1'b1;
      nextCycle();
      div_ack = 1'b0;
      div_req = 1'b0;

      // Asynchronous reset at T+20 wipes everything; no late completion.
      nextCycle();
      applyStimulus(1'b0, 32'd1000, 32'd3);
      repeat (20) nextCycle();
      #1;
      resetn = 1'b0;
      #1;
      checkOutput("rst stop", {31'd0, div_stop}, 32'd0);
      checkOutput("rst done", {31'd0, div_done}, 32'd0);
      checkOutput("rst q", div_q, 32'd0);
      checkOutput("rst r", div_r, 32'd0);
      div_req = 1'b0;
      #2;
      resetn = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         nextCycle();
         if (div_done || div_stop || div_q !== 32'd0) bad++;
      end
      checkOutput("rst stays idle", 32'(bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 integer divider for the EX stage. It produces `div_stop`, which the hazard unit turns into an EX-stage stall while a DIV/DIVU is in flight. It latches the operands when a divide enters EX and runs one quotient bit per cycle. It releases the stall in the cycle its quotient/remainder are valid for the HI/LO write.

## Interface
- `DW`, 32: operand and result width. Only 32 is verified.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `div_req` in 1: a valid DIV/DIVU is in EX (`es_valid` && divide op). Combinational from EX.
- `div_signed` in 1: 1 = DIV (signed), 0 = DIVU. Sampled on acceptance.
- `div_src1` in DW: dividend, already forwarded. Sampled on acceptance.
- `div_src2` in DW: divisor, already forwarded. Sampled on acceptance.
- `div_ack` in 1: the EX instruction leaves EX this cycle (EX ready-go && MEM allowin).
- `div_cancel` in 1: flush or exception kills the EX instruction.
- `div_stop` out 1: stall request to the hazard unit. Combinational.
- `div_done` out 1: registered. The result is valid and held.
- `div_q` out DW: quotient, to LO. Registered.
- `div_r` out DW: remainder, to HI. Registered.

## Operation
- FSM states: IDLE, BUSY, DONE. A 6-bit iteration counter `cnt` and a 2*DW-bit partial-remainder/quotient shift register.
- IDLE → BUSY when `div_req && !div_cancel`:
  - Latch |src1| and |src2|. Magnitudes are used only when `div_signed`; otherwise operands are taken raw.
  - Latch `qneg = signed & (src1[31]^src2[31])`, `rneg = signed & src1[31]`, `dz = (src2==0)`.
  - Set `cnt=0`.
- BUSY, each cycle: shift left one bit and trial-subtract the divisor from the upper half. If there is no borrow, keep the difference and set the quotient LSB to 1. Then `cnt++`.
- BUSY → DONE on the edge where `cnt==31` (the 32nd iteration). On that same edge, register the final results into `div_q`/`div_r`:
  - Apply two's-complement negation to q if `qneg`, and to r if `rneg`.
  - Set `div_done=1`.
- DONE holds `div_q`/`div_r`/`div_done` stable until `div_ack`. On `div_ack`: DONE → IDLE and `div_done` clears.
- `div_cancel` in any state: → IDLE on the next edge, `div_done` cleared, results unchanged. The cancel has priority over acceptance and over completion in the same cycle.
- `div_req` falling while BUSY without a cancel: abort to IDLE, same handling as a cancel.
- `div_stop = div_req && !div_cancel && state!=DONE`. It is forced to 0 while `resetn` is low.
- Divide by zero (`dz`): runs the full latency with no early exit. Result is `div_q=32'hFFFFFFFF`, `div_r=src1` (raw), with no sign correction, for both DIV and DIVU.
- Signed overflow, 0x80000000 / -1: natural result, q=0x80000000, r=0. No trap.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- Reset values: state=IDLE, `cnt`=0, `div_done`=0, `div_q`=0, `div_r`=0, `div_stop`=0.

## Timing
- Acceptance cycle T (IDLE, `div_req`=1): `div_stop`=1.
- T+1 … T+32: BUSY, `div_stop`=1 (32 iterations).
- T+33: DONE, `div_done`=1, results valid, `div_stop`=0, so EX may advance this cycle.
- `div_stop` is high for exactly 33 consecutive cycles per divide.
- Minimum EX occupancy is 34 cycles.
- Back-to-back divides: `div_ack` at T+33 returns the FSM to IDLE at T+34. The next divide is accepted at T+34 at the earliest, so there is one IDLE cycle between divides.
- If MEM back-pressures (`div_ack`=0 in DONE): results are held indefinitely and `div_stop` stays 0.
- Operand changes after acceptance have no effect until the next acceptance.
- Asynchronous reset mid-BUSY: all state and outputs go to their reset values immediately. No completion occurs after reset release.

## Test plan
- DIVU: 100 / 7, `div_ack` tied high.
  - `div_stop` high cycles T..T+32.
  - At T+33: `div_done`=1, q=14, r=2, `div_stop`=0.
- DIV signed sign cases:
  - -7 / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - 7 / -2 → q=0xFFFFFFFD, r=1.
  - 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
- Divide by zero: DIV 0x12345678 / 0 → completes at T+33 with q=0xFFFFFFFF, r=0x12345678.
- Back-pressure then back-to-back:
  - Hold `div_ack`=0 for 5 cycles in DONE → outputs stable, `div_stop`=0.
  - Then ack with a second DIVU 9/3 waiting → accepted one cycle after ack.
  - Second divide gives q=3, r=0 after 33 cycles.
- Cancel mid-BUSY: assert `div_cancel` at T+10.
  - `div_stop`=0 in that cycle, IDLE at T+11, `div_done` never asserts.
  - A new DIVU 10/4 accepted at T+11 gives q=2, r=2 at T+44.
- Reset mid-BUSY: drop `resetn` at T+20 → `div_stop`, `div_done`, q, r all 0 immediately. After release with `div_req`=0, the block stays IDLE.
